sc_cp0_control: RTL



---
 rtl/sc_cp0_control.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/sc_cp0_control.sv
// ============================================================================
// Module      : sc_cp0_control
// Description : CP0 state and exception/interrupt sequencing for the
//               single-cycle MIPS core (Status, Cause, EPC, Count, Compare).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sc_cp0_control #(
    parameter logic [31:0] INT_HANDLER_ADDR = 32'h0000_0180,
    parameter logic [7:0]  RESET_STATUS_IM  = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        undefined_instr,
    input  logic        overflow,
    input  logic [31:0] exception_vector,
    input  logic [31:0] pc_current,
    input  logic [4:0]  irq,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        take_exception,
    output logic        kill_instr,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc,
    output logic        exl
);

    localparam logic [4:0]  c_REG_COUNT   = 5'd9;
    localparam logic [4:0]  c_REG_COMPARE = 5'd11;
    localparam logic [4:0]  c_REG_STATUS  = 5'd12;
    localparam logic [4:0]  c_REG_CAUSE   = 5'd13;
    localparam logic [4:0]  c_REG_EPC     = 5'd14;

    localparam logic [4:0]  c_EXC_INT     = 5'd0;
    localparam logic [4:0]  c_EXC_RI      = 5'd10;
    localparam logic [4:0]  c_EXC_OV      = 5'd12;

    localparam logic [31:0] c_COMPARE_RST = 32'hFFFF_FFFF;

    logic [4:0]  r_sync1;
    logic [4:0]  r_sync2;
    logic [7:0]  r_status_im;
    logic        r_status_exl;
    logic        r_status_ie;
    logic        r_cause_ti;
    logic [1:0]  r_cause_ip_sw;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_count;
    logic [31:0] r_compare;

    logic        w_active;
    logic        w_fault;
    logic [7:0]  w_cause_ip;
    logic        w_int_req;
    logic        w_take_fault;
    logic        w_take_int;
    logic        w_do_eret;
    logic        w_do_mtc0;
    logic        w_wr_count;
    logic        w_wr_compare;
    logic        w_timer_hit;

    // Hardware IP bits are the raw synchroniser output; they are never latched.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 5'd0;
            r_sync2 <= 5'd0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
        end
    end

    assign w_active     = reset_n & enable;
    assign w_fault      = undefined_instr | overflow;
    assign w_cause_ip   = {r_cause_ti, r_sync2, r_cause_ip_sw};
    assign w_int_req    = r_status_ie & ~r_status_exl & (|(w_cause_ip & r_status_im));

    // Fixed priority: fault, interrupt, ERET, MTC0.
    assign w_take_fault = w_active & w_fault;
    assign w_take_int   = w_active & ~w_fault & w_int_req;
    assign w_do_eret    = w_active & ~w_fault & ~w_int_req & eret;
    assign w_do_mtc0    = w_active & ~w_fault & ~w_int_req & ~eret & mtc0_we;

    assign w_wr_count   = w_do_mtc0 & (cp0_addr == c_REG_COUNT);
    assign w_wr_compare = w_do_mtc0 & (cp0_addr == c_REG_COMPARE);
    assign w_timer_hit  = (r_count == r_compare);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_status_im   <= RESET_STATUS_IM;
            r_status_exl  <= 1'b0;
            r_status_ie   <= 1'b0;
            r_cause_ti    <= 1'b0;
            r_cause_ip_sw <= 2'b00;
            r_cause_exc   <= 5'd0;
            r_epc         <= 32'd0;
            r_count       <= 32'd0;
            r_compare     <= c_COMPARE_RST;
        end else if (enable) begin
            r_count    <= w_wr_count ? cp0_wdata : r_count + 32'd1;
            // A Compare write clears TI even if the match happens in the same cycle.
            r_cause_ti <= w_wr_compare ? 1'b0 : (r_cause_ti | w_timer_hit);

            if (w_take_fault) begin
                r_cause_exc <= undefined_instr ? c_EXC_RI : c_EXC_OV;
                if (!r_status_exl) begin
                    r_epc        <= pc_current;
                    r_status_exl <= 1'b1;
                end
            end else if (w_take_int) begin
                r_cause_exc  <= c_EXC_INT;
                r_epc        <= pc_current;
                r_status_exl <= 1'b1;
            end else if (w_do_eret) begin
                r_status_exl <= 1'b0;
            end else if (w_do_mtc0) begin
                case (cp0_addr)
                    c_REG_COMPARE: r_compare <= cp0_wdata;
                    c_REG_STATUS: begin
                        r_status_im  <= cp0_wdata[15:8];
                        r_status_exl <= cp0_wdata[1];
                        r_status_ie  <= cp0_wdata[0];
                    end
                    c_REG_CAUSE:   r_cause_ip_sw <= cp0_wdata[9:8];
                    c_REG_EPC:     r_epc         <= cp0_wdata;
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            c_REG_COUNT:   cp0_rdata = r_count;
            c_REG_COMPARE: cp0_rdata = r_compare;
            c_REG_STATUS:  cp0_rdata = {16'h0, r_status_im, 6'h0, r_status_exl, r_status_ie};
            c_REG_CAUSE:   cp0_rdata = {16'h0, w_cause_ip, 1'b0, r_cause_exc, 2'b00};
            c_REG_EPC:     cp0_rdata = r_epc;
            default:       cp0_rdata = 32'd0;
        endcase
    end

    always_comb begin
        redirect_pc = 32'd0;
        if (w_take_fault) begin
            redirect_pc = exception_vector;
        end else if (w_take_int) begin
            redirect_pc = INT_HANDLER_ADDR;
        end else if (w_do_eret) begin
            redirect_pc = r_epc;
        end
    end

    assign take_exception = w_take_fault | w_take_int;
    assign kill_instr     = w_take_fault | w_take_int;
    assign pc_redirect    = w_take_fault | w_take_int | w_do_eret;
    assign epc            = r_epc;
    assign exl            = r_status_exl;

endmodule

`default_nettype wire
